frame_serializer: RTL and testbench

- Upstream feeder for `pingpong_buf` in the symmetric FIR path.
- Accepts parallel samples over a valid/ready handshake and emits one bit per clock on `bit_out`, which drives `pingpong_buf.bit_in`.
- Generates the `switch` control so that each frame of exactly `MAX_COUNT` bits lands at buffer indices 0..`MAX_COUNT`-1.
- When input runs dry it parks the ping-pong buffer at index 0.

---
 rtl/fir_pkg.sv | 16 +
 rtl/counter.sv | 33 +++
 rtl/frame_serializer.sv | 172 +++++++++++++++++
 tb/tb_frame_serializer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and default sizing for the symmetric FIR serial path
// (frame_serializer feeding pingpong_buf).
package fir_pkg;

  localparam int FIR_DATA_W      = 16;
  localparam int FIR_MAX_COUNT   = 512;
  localparam int WORDS_PER_FRAME = FIR_MAX_COUNT / FIR_DATA_W;
  localparam int FIR_IDX_W       = $clog2(FIR_MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    SWAP   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/counter.sv
// Bit index counter: counts 0..MAX_COUNT-1 while enabled and wraps; clear has priority.
module counter
  import fir_pkg::*;
#(
  parameter int MAX_COUNT = WORDS_PER_FRAME * FIR_DATA_W,
  parameter int W         = FIR_IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      if (r_count == W'(MAX_COUNT - 1)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + W'(1);
      end
    end
  end

  assign count = r_count;

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial feeder for pingpong_buf: frames of MAX_COUNT bits, switch high between frames.
// Build option: define FRAME_SERIALIZER_LSB_FIRST_EN to send each word bit 0 first (default MSB first).
module frame_serializer
  import fir_pkg::*;
#(
  parameter int DATA_W    = FIR_DATA_W,
  parameter int MAX_COUNT = FIR_MAX_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              underrun_clr,
  output logic              bit_out,
  output logic              switch,
  output logic              busy,
  output logic              underrun
);

  localparam int IDX_W = $clog2(MAX_COUNT);

  ser_state_t        r_state;
  ser_state_t        w_state_next;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [DATA_W-1:0] w_word;
  logic              r_bit_out;
  logic              r_switch;
  logic              r_busy;
  logic              r_underrun;
  logic              w_bit_next;
  logic              w_consume;
  logic              w_zero_fill;
  logic              w_last;
  logic              w_slot_edge;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic [IDX_W-1:0]  w_idx;

`ifdef FRAME_SERIALIZER_LSB_FIRST_EN
  function automatic logic first_bit(input logic [DATA_W-1:0] word);
    return word[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] word);
    return word >> 1;
  endfunction
`else
  function automatic logic first_bit(input logic [DATA_W-1:0] word);
    return word[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] word);
    return word << 1;
  endfunction
`endif

  assign w_cnt_clr = (r_state != STREAM);
  assign w_cnt_en  = (r_state == STREAM);

  counter #(
    .MAX_COUNT (MAX_COUNT),
    .W         (IDX_W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .en    (w_cnt_en),
    .count (w_idx)
  );

  assign w_last      = (w_idx == IDX_W'(MAX_COUNT - 1));
  // True when the coming edge starts a new word slot inside the current frame.
  assign w_slot_edge = !w_last && (((int'(w_idx) + 1) % DATA_W) == 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    w_zero_fill  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_valid) begin
          w_state_next = STREAM;
          w_consume    = 1'b1;
        end
      end
      STREAM: begin
        if (w_last) begin
          w_state_next = SWAP;
        end else if (w_slot_edge) begin
          if (r_hold_valid) begin
            w_consume = 1'b1;
          end else begin
            w_zero_fill = 1'b1;
          end
        end
      end
      SWAP: begin
        if (r_hold_valid) begin
          w_state_next = STREAM;
          w_consume    = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // A zero-filled slot loads an all-zero word so the whole slot reads 0.
    w_word = w_consume ? r_hold : '0;
    if (w_consume || w_zero_fill) begin
      w_bit_next   = first_bit(w_word);
      w_shift_next = shift_out(w_word);
    end else if ((r_state == STREAM) && !w_last) begin
      w_bit_next   = first_bit(r_shift);
      w_shift_next = shift_out(r_shift);
    end else begin
      w_bit_next   = 1'b0;
      w_shift_next = r_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_consume) begin
      r_hold_valid <= 1'b0;
    end else if (s_valid && !r_hold_valid) begin
      r_hold       <= s_data;
      r_hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bit_out  <= 1'b0;
      r_switch   <= 1'b1;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_shift   <= w_shift_next;
      r_bit_out <= w_bit_next;
      r_switch  <= (w_state_next != STREAM);
      r_busy    <= (w_state_next != IDLE);
      if (w_zero_fill) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign s_ready  = ~r_hold_valid;
  assign bit_out  = r_bit_out;
  assign switch   = r_switch;
  assign busy     = r_busy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer with DATA_W=16, MAX_COUNT=64 (4 words per frame).
module tb_frame_serializer;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        underrun_clr;
  logic        bit_out;
  logic        switch;
  logic        busy;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  frame_serializer #(
    .DATA_W    (16),
    .MAX_COUNT (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .underrun_clr (underrun_clr),
    .bit_out      (bit_out),
    .switch       (switch),
    .busy         (busy),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] order16(input logic [15:0] w);
`ifdef FRAME_SERIALIZER_LSB_FIRST_EN
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[15-b] = w[b];
    return r;
`else
    return w;
`endif
  endfunction

  function automatic logic [63:0] expect_frame(input logic [15:0] w0, input logic [15:0] w1,
                                               input logic [15:0] w2, input logic [15:0] w3);
    return {order16(w0), order16(w1), order16(w2), order16(w3)};
  endfunction

  // Presents words in order; word i is not offered before cycle base+g[i].
  task automatic feed(input logic [15:0] w[8], input int g[8], input int n);
    int i;
    int base;
    bit hs;
    i = 0;
    hs = 1'b0;
    base = cyc;
    for (int t = 0; t < 400 && i < n; t++) begin
      if (t > 0) @(negedge clk);
      if (hs) i++;
      if (i < n && (cyc - base) >= g[i]) begin
        s_valid = 1'b1;
        s_data  = w[i];
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
      end
      hs = s_valid && s_ready;
    end
    s_valid = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: words accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic wait_stream(output int start, output bit ok);
    ok = 1'b0;
    start = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (busy && !switch) begin
        start = cyc;
        ok = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL stream_start_timeout: busy=%b switch=%b required busy=1 switch=0", busy, switch);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: busy=%b required 0", busy);
  endtask

  task automatic capture_frame(output logic [63:0] bits, output int start);
    bit ok;
    logic bad;
    bits = '0;
    wait_stream(start, ok);
    if (!ok) return;
    bits = {63'd0, bit_out};
    bad = 1'b0;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      bits = {bits[62:0], bit_out};
      bad = bad | switch | !busy;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL stream_ctrl: switch/busy disturbed during frame, flag=%b required 0", bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (switch !== 1'b1)   begin errors++; $display("FAIL reset_switch: got %b want 1", switch); end
    checks++; if (bit_out !== 1'b0)  begin errors++; $display("FAIL reset_bit_out: got %b want 0", bit_out); end
    checks++; if (s_ready !== 1'b1)  begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    $display("test_reset done");
  endtask

  task automatic run_frame(input string name, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w[8];
    int g[8];
    logic [63:0] got;
    logic [63:0] exp;
    int start;
    int base;
    w = '{w0, w1, w2, w3, 16'h0, 16'h0, 16'h0, 16'h0};
    g = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp = expect_frame(w0, w1, w2, w3);
    @(negedge clk);
    base = cyc;
    fork
      feed(w, g, 4);
      capture_frame(got, start);
    join
    checks++; if (got !== exp) begin errors++; $display("FAIL %s_bits: got %h want %h", name, got, exp); end
    checks++; if (start - base !== 2) begin errors++; $display("FAIL %s_latency: got %0d want 2", name, start - base); end
    @(negedge clk);
    checks++; if ({switch, busy, bit_out} !== 3'b110) begin
      errors++; $display("FAIL %s_swap: switch,busy,bit_out got %b want 110", name, {switch, busy, bit_out});
    end
    @(negedge clk);
    checks++; if ({switch, busy} !== 2'b10) begin
      errors++; $display("FAIL %s_idle: switch,busy got %b want 10", name, {switch, busy});
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL %s_underrun: got %b want 0", name, underrun); end
    $display("%s frame: %h", name, got);
  endtask

  task automatic test_single_frame();
    run_frame("single", 16'hA5F0, 16'h0001, 16'h8000, 16'hFFFF);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[8];
    int g[8];
    logic [63:0] got1, got2;
    int s1, s2;
    w = '{16'hA5F0, 16'h0001, 16'h8000, 16'hFFFF, 16'h1357, 16'h2468, 16'h0F0F, 16'hF00F};
    g = '{0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    fork
      feed(w, g, 8);
      begin
        capture_frame(got1, s1);
        @(negedge clk);
        checks++; if ({switch, bit_out} !== 2'b10) begin
          errors++; $display("FAIL b2b_swap: switch,bit_out got %b want 10", {switch, bit_out});
        end
        capture_frame(got2, s2);
        wait_idle();
      end
    join
    checks++; if (got1 !== expect_frame(16'hA5F0, 16'h0001, 16'h8000, 16'hFFFF)) begin
      errors++; $display("FAIL b2b_frame1: got %h want %h", got1, expect_frame(16'hA5F0, 16'h0001, 16'h8000, 16'hFFFF));
    end
    checks++; if (got2 !== expect_frame(16'h1357, 16'h2468, 16'h0F0F, 16'hF00F)) begin
      errors++; $display("FAIL b2b_frame2: got %h want %h", got2, expect_frame(16'h1357, 16'h2468, 16'h0F0F, 16'hF00F));
    end
    checks++; if (s2 - s1 !== 65) begin errors++; $display("FAIL b2b_period: got %0d want 65", s2 - s1); end
    $display("back_to_back frames: %h %h period=%0d", got1, got2, s2 - s1);
  endtask

  // Word 2 handshakes on the edge starting slot 1's last bit: still on time.
  task automatic test_deadline();
    logic [15:0] w[8];
    int g[8];
    logic [63:0] got;
    int s;
    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
    g = '{0, 0, 32, 0, 0, 0, 0, 0};
    @(negedge clk);
    fork
      feed(w, g, 4);
      begin
        capture_frame(got, s);
        wait_idle();
      end
    join
    checks++; if (got !== expect_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444)) begin
      errors++; $display("FAIL deadline_bits: got %h want %h", got, expect_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444));
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL deadline_underrun: got %b want 0", underrun); end
    $display("deadline frame: %h", got);
  endtask

  // Word 2 handshakes on the slot-2 start edge: slot 2 zero-filled, word used in slot 3.
  task automatic test_underrun();
    logic [15:0] w[8];
    int g[8];
    logic [63:0] got;
    int s;
    w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0, 16'h0, 16'h0, 16'h0};
    g = '{0, 0, 33, 0, 0, 0, 0, 0};
    @(negedge clk);
    fork
      feed(w, g, 4);
      capture_frame(got, s);
    join
    checks++; if (got !== expect_frame(16'h1234, 16'h5678, 16'h0000, 16'h9ABC)) begin
      errors++; $display("FAIL underrun_bits: got %h want %h", got, expect_frame(16'h1234, 16'h5678, 16'h0000, 16'h9ABC));
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b want 1", underrun); end
    wait_idle();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clr: got %b want 0", underrun); end
    $display("underrun frame: %h", got);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w[8];
    int g[8];
    int s;
    bit ok;
    w = '{16'hCAFE, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    g = '{0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    fork
      feed(w, g, 2);
      begin
        wait_stream(s, ok);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (switch !== 1'b1)   begin errors++; $display("FAIL midrst_switch: got %b want 1", switch); end
        checks++; if (bit_out !== 1'b0)  begin errors++; $display("FAIL midrst_bit_out: got %b want 0", bit_out); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (s_ready !== 1'b1)  begin errors++; $display("FAIL midrst_s_ready: got %b want 1", s_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun: got %b want 0", underrun); end
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset_mid_frame applied at index 30");
    run_frame("after_reset", 16'h0F0F, 16'h1234, 16'h5678, 16'h9ABC);
  endtask

  task automatic test_word_order();
    logic [15:0] w[8];
    int g[8];
    logic [63:0] got;
    logic [15:0] exp_slot0;
    int s;
    w = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    g = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef FRAME_SERIALIZER_LSB_FIRST_EN
    exp_slot0 = 16'h8000;
`else
    exp_slot0 = 16'h0001;
`endif
    @(negedge clk);
    fork
      feed(w, g, 4);
      begin
        capture_frame(got, s);
        wait_idle();
      end
    join
    checks++; if (got[63:48] !== exp_slot0) begin
      errors++; $display("FAIL word_order: first 16 bits got %h want %h", got[63:48], exp_slot0);
    end
    $display("word_order slot0: %h", got[63:48]);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_deadline();
    test_underrun();
    test_reset_mid_frame();
    test_word_order();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
